// File: rtl/sim_test_monitor_pkg.sv
// Shared definitions for the self-test verdict monitor: state encodings,
// the protocol flag value and default parameter values.
package sim_test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  // Value the test program writes into x26/x27 to signal done/pass.
  localparam int TEST_FLAG_ONE = 1;

  localparam int DEF_XLEN           = 32;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 100000;
  localparam int DEF_SETTLE_CYCLES  = 10;
  localparam int DEF_STALL_LIMIT    = 64;

  function automatic logic is_verdict(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
  endfunction

endpackage

// File: rtl/sim_test_monitor_if.sv
// Bundle of register taps from the core and verdict outputs of the monitor.
// master = core/bench side driving the taps, slave = the monitor.
interface sim_test_monitor_if #(
  parameter int XLEN  = sim_test_monitor_pkg::DEF_XLEN,
  parameter int CNT_W = sim_test_monitor_pkg::DEF_CNT_W
);
  logic             en_i;
  logic             clr_i;
  logic [XLEN-1:0]  done_flag_i;
  logic [XLEN-1:0]  pass_flag_i;
  logic [XLEN-1:0]  testnum_i;
  logic [XLEN-1:0]  pc_i;

  logic [2:0]       state_o;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic             hang_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [XLEN-1:0]  fail_testnum_o;
  logic [XLEN-1:0]  final_pc_o;

  modport master (
    output en_i, clr_i, done_flag_i, pass_flag_i, testnum_i, pc_i,
    input  state_o, done_o, pass_o, fail_o, timeout_o, hang_o,
           cycle_cnt_o, fail_testnum_o, final_pc_o
  );

  modport slave (
    input  en_i, clr_i, done_flag_i, pass_flag_i, testnum_i, pc_i,
    output state_o, done_o, pass_o, fail_o, timeout_o, hang_o,
           cycle_cnt_o, fail_testnum_o, final_pc_o
  );
endinterface

// File: rtl/sim_test_monitor_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones instead of wrapping.
module sim_test_monitor_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Synchronous clear has priority; increment only below the ceiling.
  always_ff @(posedge clk) begin
    if (rest || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/sim_test_monitor.sv
// Self-test verdict monitor for the RV32 core. Watches the done/pass flag
// registers, the test number and the PC, and latches a sticky verdict.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | test executing; counting cycles, watching for done/stall
// ST_SETTLE  | done seen; waiting for the pass flag to become stable
// ST_PASS    | pass flag was exactly 1 at the sampling cycle
// ST_FAIL    | pass flag was anything other than 1
// ST_TIMEOUT | cycle budget exhausted without done
// ST_HANG    | PC unchanged for STALL_LIMIT consecutive RUN cycles
module sim_test_monitor
  import sim_test_monitor_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int STALL_LIMIT    = DEF_STALL_LIMIT
) (
  input logic              clk,
  input logic              rest,
  sim_test_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  // Meaningless when STALL_LIMIT is 0; hang_hit is gated off in that case.
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_LIMIT - 1);
  localparam logic [XLEN-1:0]  FLAG_ONE     = XLEN'(TEST_FLAG_ONE);

  state_e           state_q, state_d;
  logic             sync_rst;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, settle_cnt;
  logic [XLEN-1:0]  prev_pc;
  logic             run_active, pc_same;
  logic             done_hit, timeout_hit, hang_hit, settle_last;
  logic             cycle_inc, verdict_entry;

  logic             done_q, pass_q, fail_q, timeout_q, hang_q;
  logic [XLEN-1:0]  fail_testnum_q, final_pc_q;

  // clr_i is a full restart, indistinguishable from reset.
  assign sync_rst    = rest | bus.clr_i;

  assign run_active  = (state_q == ST_RUN) && bus.en_i;
  assign pc_same     = (bus.pc_i == prev_pc);
  assign done_hit    = (bus.done_flag_i == FLAG_ONE);
  assign timeout_hit = (cycle_cnt == TIMEOUT_LAST);
  assign hang_hit    = (STALL_LIMIT != 0) && (stall_cnt == STALL_LAST) && pc_same;
  assign settle_last = (settle_cnt == SETTLE_LAST);

  // Next-state decode; done outranks timeout, which outranks hang.
  always_comb begin
    state_d   = state_q;
    cycle_inc = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.en_i) begin
          if (done_hit) begin
            state_d = ST_SETTLE;
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
          end else if (hang_hit) begin
            state_d = ST_HANG;
          end else begin
            cycle_inc = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        cycle_inc = 1'b1;
        if (settle_last) begin
          state_d = (bus.pass_flag_i == FLAG_ONE) ? ST_PASS : ST_FAIL;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign verdict_entry = is_verdict(state_d) && !is_verdict(state_q);

  sim_test_monitor_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk  (clk),
    .rest (sync_rst),
    .clr  (1'b0),
    .en   (cycle_inc),
    .q    (cycle_cnt)
  );

  sim_test_monitor_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rest (sync_rst),
    .clr  (run_active && !pc_same),
    .en   (run_active && pc_same),
    .q    (stall_cnt)
  );

  // Held at zero outside SETTLE so it always starts from 0 on entry.
  sim_test_monitor_sat_counter #(.W(CNT_W)) u_settle_cnt (
    .clk  (clk),
    .rest (sync_rst),
    .clr  (state_q != ST_SETTLE),
    .en   (state_q == ST_SETTLE),
    .q    (settle_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC history for stall detection; frozen while paused or outside RUN.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      prev_pc <= '0;
    end else if (run_active) begin
      prev_pc <= bus.pc_i;
    end
  end

  // Registered verdict flags and the snapshot taken when a verdict is reached.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      hang_q         <= 1'b0;
      fail_testnum_q <= '0;
      final_pc_q     <= '0;
    end else begin
      done_q    <= is_verdict(state_d);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      timeout_q <= (state_d == ST_TIMEOUT);
      hang_q    <= (state_d == ST_HANG);
      if (verdict_entry) begin
        fail_testnum_q <= bus.testnum_i;
        final_pc_q     <= bus.pc_i;
      end
    end
  end

  assign bus.state_o        = state_q;
  assign bus.done_o         = done_q;
  assign bus.pass_o         = pass_q;
  assign bus.fail_o         = fail_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.hang_o         = hang_q;
  assign bus.cycle_cnt_o    = cycle_cnt;
  assign bus.fail_testnum_o = fail_testnum_q;
  assign bus.final_pc_o     = final_pc_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor. Two monitors share the stimulus:
// dut_a (timeout 16, stall limit 4) and dut_b (timeout 64, hang disabled).
// Only one is out of reset per scenario.
module tb_sim_test_monitor;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cnt;
    logic [31:0] tn;
    logic [31:0] pc;
    int          edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        en, clr;
  logic [31:0] done_f, pass_f, tnum, pc;

  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  sim_test_monitor_if #(.XLEN(32), .CNT_W(32)) if_a ();
  sim_test_monitor_if #(.XLEN(32), .CNT_W(32)) if_b ();

  assign if_a.en_i = en;        assign if_b.en_i = en;
  assign if_a.clr_i = clr;      assign if_b.clr_i = clr;
  assign if_a.done_flag_i = done_f; assign if_b.done_flag_i = done_f;
  assign if_a.pass_flag_i = pass_f; assign if_b.pass_flag_i = pass_f;
  assign if_a.testnum_i = tnum; assign if_b.testnum_i = tnum;
  assign if_a.pc_i = pc;        assign if_b.pc_i = pc;

  sim_test_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT_CYCLES(16),
                     .SETTLE_CYCLES(10), .STALL_LIMIT(4)) dut_a (
    .clk  (clk),
    .rest (rst_a),
    .bus  (if_a)
  );

  sim_test_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT_CYCLES(64),
                     .SETTLE_CYCLES(10), .STALL_LIMIT(0)) dut_b (
    .clk  (clk),
    .rest (rst_b),
    .bus  (if_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [2:0] st);
    case (st)
      3'd2:    return 4'b0001;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check_verdict(input string tag, input bit is_a, input logic [2:0] st,
                               input logic [3:0] fl, input logic [31:0] cnt,
                               input logic [31:0] tn, input logic [31:0] vpc);
    exp_t e;
    if ((is_a && q_a.size() == 0) || (!is_a && q_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected actual_state=%0d required=no_verdict", tag, st);
      return;
    end
    if (is_a) e = q_a.pop_front();
    else      e = q_b.pop_front();
    chk({tag, "_state"}, 64'(st), 64'(e.st));
    chk({tag, "_flags"}, 64'(fl), 64'(flags_of(e.st)));
    chk({tag, "_cycle_cnt"}, 64'(cnt), 64'(e.cnt));
    chk({tag, "_testnum"}, 64'(tn), 64'(e.tn));
    chk({tag, "_final_pc"}, 64'(vpc), 64'(e.pc));
    chk({tag, "_edge"}, 64'(edge_n), 64'(e.edge_no));
  endtask

  // Monitor: a rising done_o means the DUT is presenting a verdict.
  always @(negedge clk) begin
    if (if_a.done_o && !prev_a)
      check_verdict("dut_a", 1'b1, if_a.state_o,
                    {if_a.hang_o, if_a.timeout_o, if_a.fail_o, if_a.pass_o},
                    if_a.cycle_cnt_o, if_a.fail_testnum_o, if_a.final_pc_o);
    if (if_b.done_o && !prev_b)
      check_verdict("dut_b", 1'b0, if_b.state_o,
                    {if_b.hang_o, if_b.timeout_o, if_b.fail_o, if_b.pass_o},
                    if_b.cycle_cnt_o, if_b.fail_testnum_o, if_b.final_pc_o);
    prev_a = if_a.done_o;
    prev_b = if_b.done_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_steps(input int n);
    repeat (n) begin
      step();
      pc = pc + 32'd4;
    end
  endtask

  task automatic push_exp(input bit is_a, input logic [2:0] st, input logic [31:0] cnt,
                          input logic [31:0] tn, input logic [31:0] vpc, input int e_no);
    exp_t e;
    e.st = st; e.cnt = cnt; e.tn = tn; e.pc = vpc; e.edge_no = e_no;
    if (is_a) q_a.push_back(e);
    else      q_b.push_back(e);
  endtask

  task automatic wait_verdict(input string tag, input bit is_a, input int bound);
    for (int i = 0; i < bound; i++) begin
      if ((is_a && q_a.size() == 0) || (!is_a && q_b.size() == 0)) return;
      step();
    end
    if ((is_a && q_a.size() != 0) || (!is_a && q_b.size() != 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_no_verdict waited=%0d cycles required=verdict", tag, bound);
      if (is_a) q_a.delete();
      else      q_b.delete();
    end
  endtask

  task automatic reset_all();
    rst_a = 1'b1; rst_b = 1'b1;
    en = 1'b1; clr = 1'b0;
    done_f = '0; pass_f = '0; tnum = '0; pc = '0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_all();
    chk("reset_state", 64'(if_a.state_o), 64'd0);
    chk("reset_flags", 64'({if_a.done_o, if_a.hang_o, if_a.timeout_o, if_a.fail_o, if_a.pass_o}), 64'd0);
    chk("reset_cycle_cnt", 64'(if_a.cycle_cnt_o), 64'd0);
    chk("reset_testnum_pc", {if_a.fail_testnum_o, if_a.final_pc_o}, 64'd0);

    // Pass: done at cycle 20, verdict 10 edges later with cycle_cnt 30.
    reset_all();
    rst_b = 1'b0; pc = 32'h1000; tnum = 32'd5;
    run_steps(20);
    done_f = 32'd1; pass_f = 32'd1;
    push_exp(1'b0, 3'd2, 32'd30, 32'd5, pc, edge_n + 11);
    step();
    done_f = 32'd0;
    wait_verdict("pass", 1'b0, 20);

    // Fail: pass flag 0, then verdict must hold for 50 cycles.
    reset_all();
    rst_b = 1'b0; pc = 32'h10; tnum = 32'd1;
    run_steps(5);
    done_f = 32'd1; pass_f = 32'd0; tnum = 32'd7; pc = 32'h80;
    push_exp(1'b0, 3'd3, 32'd15, 32'd7, 32'h80, edge_n + 11);
    wait_verdict("fail", 1'b0, 20);
    tnum = 32'd9; pc = 32'h200; done_f = 32'd0; pass_f = 32'd1;
    repeat (50) step();
    chk("fail_hold_state", 64'(if_b.state_o), 64'd3);
    chk("fail_hold_flags", 64'({if_b.done_o, if_b.hang_o, if_b.timeout_o, if_b.fail_o, if_b.pass_o}), 64'b10010);
    chk("fail_hold_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd15);
    chk("fail_hold_testnum", 64'(if_b.fail_testnum_o), 64'd7);
    chk("fail_hold_pc", 64'(if_b.final_pc_o), 64'h80);

    // Pass flag must equal 1 across the full width.
    reset_all();
    rst_b = 1'b0; pc = 32'h20; tnum = 32'd8;
    run_steps(2);
    done_f = 32'd1; pass_f = 32'h8000_0001; pc = 32'h90;
    push_exp(1'b0, 3'd3, 32'd12, 32'd8, 32'h90, edge_n + 11);
    wait_verdict("fail_wide", 1'b0, 20);

    // Timeout at 16 edges; done_flag of 2 is not a done.
    reset_all();
    rst_a = 1'b0; done_f = 32'd2; tnum = 32'd11; pc = 32'h100;
    push_exp(1'b1, 3'd4, 32'd15, 32'd11, 32'h13C, edge_n + 16);
    run_steps(16);
    wait_verdict("timeout", 1'b1, 4);

    // Done on the would-be timeout edge wins; constant PC in SETTLE is not a hang.
    reset_all();
    rst_a = 1'b0; tnum = 32'd13; pc = 32'h100;
    run_steps(15);
    done_f = 32'd1; pass_f = 32'd1;
    push_exp(1'b1, 3'd2, 32'd25, 32'd13, 32'h13C, edge_n + 11);
    wait_verdict("done_vs_timeout", 1'b1, 20);

    // Hang: stuck PC, 5 edges (first one loads prev_pc).
    reset_all();
    rst_a = 1'b0; pc = 32'h44; tnum = 32'd12;
    push_exp(1'b1, 3'd5, 32'd4, 32'd12, 32'h44, edge_n + 5);
    wait_verdict("hang", 1'b1, 10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_terminal_state", 64'(if_a.state_o), 64'd0);
    chk("clr_terminal_flags", 64'({if_a.done_o, if_a.hang_o, if_a.timeout_o, if_a.fail_o, if_a.pass_o}), 64'd0);
    chk("clr_terminal_snap", {if_a.fail_testnum_o, if_a.final_pc_o}, 64'd0);

    // Hang detection disabled: same stuck PC runs into the timeout.
    reset_all();
    rst_b = 1'b0; pc = 32'h44; tnum = 32'd14;
    push_exp(1'b0, 3'd4, 32'd63, 32'd14, 32'h44, edge_n + 64);
    wait_verdict("no_hang", 1'b0, 70);

    // Pause freezes counting; clr_i mid-SETTLE restarts cleanly.
    reset_all();
    rst_b = 1'b0; pc = 32'h300; tnum = 32'd3;
    run_steps(10);
    en = 1'b0;
    run_steps(8);
    chk("pause_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd10);
    chk("pause_state", 64'(if_b.state_o), 64'd0);
    en = 1'b1;
    run_steps(5);
    chk("resume_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd15);
    done_f = 32'd1; pass_f = 32'd1;
    step();
    en = 1'b0;
    step();
    step();
    chk("settle_state", 64'(if_b.state_o), 64'd1);
    chk("settle_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd17);
    clr = 1'b1; done_f = 32'd0; en = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_settle_state", 64'(if_b.state_o), 64'd0);
    chk("clr_settle_flags", 64'({if_b.done_o, if_b.hang_o, if_b.timeout_o, if_b.fail_o, if_b.pass_o}), 64'd0);
    chk("clr_settle_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd0);
    chk("clr_settle_snap", {if_b.fail_testnum_o, if_b.final_pc_o}, 64'd0);
    run_steps(4);
    chk("restart_cycle_cnt", 64'(if_b.cycle_cnt_o), 64'd4);
    repeat (12) step();
    chk("restart_still_running", 64'(if_b.state_o), 64'd0);

    reset_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Parametrised, synthesizable self-test verdict monitor for the RV32 core, instantiated beside cpu_top in benches or FPGA builds.
- Watches the core's test-protocol registers: done flag (x26), pass flag (x27), test number (x3) and the PC.
- Produces a sticky verdict: PASS, FAIL, TIMEOUT or HANG, with cycle count, failing test number and final PC.
- Replaces ad-hoc wait/delay/display logic in testbenches with cycle-accurate hardware.

Parameters:
- XLEN, 32, width of register taps and PC.
- CNT_W, 32, width of cycle counter.
- TIMEOUT_CYCLES, 100000, RUN cycles before TIMEOUT; must be >= 1.
- SETTLE_CYCLES, 10, cycles waited after done before sampling pass flag; must be >= 1.
- STALL_LIMIT, 64, consecutive unchanged-PC RUN cycles before HANG; 0 disables hang detection.

Ports:
- clk  in  1  core clock.
- rest  in  1  synchronous reset, active-high.
- en_i  in  1  monitoring enable; low pauses RUN counting.
- clr_i  in  1  synchronous restart to RUN with counters cleared (same effect as rest).
- done_flag_i  in  XLEN  x26 tap.
- pass_flag_i  in  XLEN  x27 tap.
- testnum_i  in  XLEN  x3 tap.
- pc_i  in  XLEN  current PC.
- state_o  out  3  encoded state.
- done_o  out  1  verdict reached (any terminal state).
- pass_o / fail_o / timeout_o / hang_o  out  1 each  one-hot verdict flags.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed; saturating.
- fail_testnum_o  out  XLEN  testnum_i latched at verdict.
- final_pc_o  out  XLEN  pc_i latched at verdict.

Behaviour:
- Reset (rest or clr_i high at posedge):
  - state=RUN; all flags 0; cycle_cnt_o, fail_testnum_o, final_pc_o, stall counter and settle counter = 0; prev_pc = 0.
  - rest and clr_i are identical in effect and override all other inputs, including mid-SETTLE or in a terminal state.
- States: RUN=0, SETTLE=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5. Encodings 6 and 7 return to RUN.
- RUN, when en_i=1, in priority order:
  1. done_flag_i == 1 (full-width compare): go to SETTLE, settle_cnt=0. Done wins over a simultaneous timeout or hang.
  2. cycle_cnt_o == TIMEOUT_CYCLES-1: go to TIMEOUT.
  3. STALL_LIMIT != 0 and stall_cnt == STALL_LIMIT-1 and pc_i == prev_pc: go to HANG.
  4. Otherwise cycle_cnt_o increments, saturating at all-ones.
  - Stall counter: stall_cnt increments when pc_i == prev_pc, clears otherwise; prev_pc <= pc_i every enabled RUN cycle.
- RUN, when en_i=0: all counters and prev_pc hold; no transitions.
- SETTLE:
  - Ignores en_i, timeout and hang; cycle_cnt_o continues incrementing.
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1: pass_flag_i is sampled that cycle. Value == 1 goes to PASS; any other value goes to FAIL.
  - A done flag that drops during SETTLE is ignored.
- Terminal states (PASS/FAIL/TIMEOUT/HANG):
  - Sticky until rest or clr_i; cycle_cnt_o frozen.
  - On the entering transition, fail_testnum_o <= testnum_i and final_pc_o <= pc_i (latched for all verdicts).
- Outputs:
  - All outputs are registered; the flag matching state_o is 1 the cycle after the deciding edge.
  - done_o = OR of the four verdict flags.
  - Latency: done seen at edge N gives verdict visible after edge N+SETTLE_CYCLES.

Decomposition:
- Shared package / include (global.v style): state encodings ST_RUN..ST_HANG, constant TEST_FLAG_ONE = 1, default parameter values.
- One natural sub-module: sat_counter (width-parametrised, enable, clear, saturating increment), used for cycle, stall and settle counters.

Test Plan:
- Pass: done=1 at RUN cycle 20, pass=1, SETTLE_CYCLES=10 -> pass_o=1 after 10 further edges; cycle_cnt_o=30; fail_testnum_o=testnum_i.
- Fail: done=1, pass=0, testnum=7, pc=0x80 -> fail_o=1, fail_testnum_o=7, final_pc_o=0x80; holds 50 cycles unchanged.
- Timeout: TIMEOUT_CYCLES=16, PC incrementing, done=0 -> timeout_o=1 after 16 RUN edges; cycle_cnt_o=15. Then done=1 at the 16th edge -> SETTLE taken, not TIMEOUT.
- Hang: STALL_LIMIT=4, pc stuck at 0x44 -> hang_o after 5 edges of equal PC (first edge loads prev_pc). Same run with STALL_LIMIT=0 -> no hang; times out.
- Pause/restart: en_i=0 for 8 cycles mid-RUN -> cycle_cnt_o frozen. clr_i during SETTLE -> state_o=0, all outputs 0 next cycle.
